// File: rtl/me2_branch_pkg.sv
// rtl/me2_branch_pkg.sv - branch-resolution shared encodings and counter helper
package me2_branch_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_JUMP = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BEQ  = 3'd3;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // True when the low w bits of v are all ones, i.e. a w-bit counter must hold.
    function automatic logic cnt_saturated(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v & mask) == mask;
    endfunction

endpackage

// File: rtl/me2_branch_resolve_t_cond.sv
// rtl/me2_branch_resolve_t_cond.sv - combinational branch condition evaluation
module br_cond_t
    import me2_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branchop,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    // Relational operators on full-width values, so no subtraction overflow can leak in.
    always_comb begin
        taken = 1'b0;
        case (branchop)
            BR_NONE: taken = 1'b0;
            BR_JUMP: taken = 1'b1;
            BR_BNE:  taken = (rs1 != rs2);
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/me2_branch_resolve_t.sv
// rtl/me2_branch_resolve_t.sv - me2 branch resolve, mispredict redirect and flush
module me2_branch_resolve_t
    import me2_branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             STALL,
    input  logic [2:0]       r_me2_branchop_Q,
    input  logic [XLEN-1:0]  r_me2_rs1_Q,
    input  logic [XLEN-1:0]  r_me2_rs2_Q,
    input  logic             r_me2_pred_taken_Q,
    input  logic [XLEN-1:0]  r_me2_target_Q,
    input  logic [XLEN-1:0]  r_me2_fallthru_Q,
    output logic             s_me2_pcsrc_D,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    state_t     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic       taken;
    logic       squash;
    logic       accept;
    logic       mispredict;

    br_cond_t #(.XLEN(XLEN)) u_cond (
        .branchop (r_me2_branchop_Q),
        .rs1      (r_me2_rs1_Q),
        .rs2      (r_me2_rs2_Q),
        .taken    (taken)
    );

    // Anything in this stage while flushing is younger than the mispredicted branch.
    assign squash        = (state_q == ST_FLUSH);
    assign s_me2_pcsrc_D = ACT && !squash && taken;
    assign accept        = ACT && !STALL && !squash && (r_me2_branchop_Q != BR_NONE);
    assign mispredict    = accept && (taken != r_me2_pred_taken_Q);
    assign flush         = squash;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                // Counts down through STALL; the redirect must not wait on the pipeline.
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= taken ? r_me2_target_Q : r_me2_fallthru_Q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (accept && !cnt_saturated(64'(br_count), CNT_W)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mispredict && !cnt_saturated(64'(mispred_count), CNT_W)) begin
                mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_me2_branch_resolve_t.sv
// tb/tb_me2_branch_resolve_t.sv - scoreboard bench for me2_branch_resolve_t
module tb_me2_branch_resolve_t;

    localparam int FC = 2;

    logic        CLK = 1'b0;
    logic        RST, ACT, STALL, pred;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, tgt, ft;

    logic        pcsrc, rv, fl;
    logic [31:0] rpc, bc, mc;
    logic        pcsrc4, rv4, fl4;
    logic [31:0] rpc4;
    logic [3:0]  bc4, mc4;

    always #5 CLK = ~CLK;

    me2_branch_resolve_t #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .STALL(STALL),
        .r_me2_branchop_Q(op), .r_me2_rs1_Q(rs1), .r_me2_rs2_Q(rs2),
        .r_me2_pred_taken_Q(pred), .r_me2_target_Q(tgt), .r_me2_fallthru_Q(ft),
        .s_me2_pcsrc_D(pcsrc), .redirect_valid(rv), .redirect_pc(rpc), .flush(fl),
        .br_count(bc), .mispred_count(mc)
    );

    me2_branch_resolve_t #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .ACT(ACT), .STALL(STALL),
        .r_me2_branchop_Q(op), .r_me2_rs1_Q(rs1), .r_me2_rs2_Q(rs2),
        .r_me2_pred_taken_Q(pred), .r_me2_target_Q(tgt), .r_me2_fallthru_Q(ft),
        .s_me2_pcsrc_D(pcsrc4), .redirect_valid(rv4), .redirect_pc(rpc4), .flush(fl4),
        .br_count(bc4), .mispred_count(mc4)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic [31:0] bc;
        logic [31:0] mc;
        logic [3:0]  bc4;
        logic [3:0]  mc4;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    int          m_fl;
    logic [31:0] m_rpc;
    int unsigned m_bc, m_mc, m_bc4, m_mc4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return a != b;
            3'd3: return a == b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            default: return a >= b;
        endcase
    endfunction

    function automatic exp_t snapshot(input logic r);
        exp_t e;
        e.rv  = r;
        e.rpc = m_rpc;
        e.fl  = (m_fl > 0);
        e.bc  = m_bc;
        e.mc  = m_mc;
        e.bc4 = 4'(m_bc4);
        e.mc4 = 4'(m_mc4);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check("redirect_valid", 64'(rv),  64'(e.rv));
        check("redirect_pc",    64'(rpc), 64'(e.rpc));
        check("flush",          64'(fl),  64'(e.fl));
        check("br_count",       64'(bc),  64'(e.bc));
        check("mispred_count",  64'(mc),  64'(e.mc));
        check("br_count4",      64'(bc4), 64'(e.bc4));
        check("mispred_count4", 64'(mc4), 64'(e.mc4));
        check("flush4",         64'(fl4), 64'(e.fl));
        check("redirect_valid4",64'(rv4), 64'(e.rv));
    endtask

    task automatic do_reset();
        RST = 1'b1; ACT = 1'b0; STALL = 1'b0; op = 3'd0; pred = 1'b0;
        m_fl = 0; m_rpc = '0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        sb.push_back(snapshot(1'b0));
        @(posedge CLK); #1;
        compare_out();
        RST = 1'b0;
    endtask

    task automatic step(input logic a, input logic s, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y, input logic p,
                        input logic [31:0] t, input logic [31:0] f);
        logic tk, acc, mis;
        ACT = a; STALL = s; op = o; rs1 = x; rs2 = y; pred = p; tgt = t; ft = f;
        #1;
        tk = ref_taken(o, x, y);
        check("pcsrc",  64'(pcsrc),  64'(a && (m_fl == 0) && tk));
        check("pcsrc4", 64'(pcsrc4), 64'(a && (m_fl == 0) && tk));
        acc = a && !s && (o != 3'd0) && (m_fl == 0);
        mis = acc && (tk != p);
        if (mis) m_rpc = tk ? t : f;
        if (m_fl > 0) m_fl--;
        else if (mis) m_fl = FC;
        if (acc) begin
            m_bc++;
            if (m_bc4 < 15) m_bc4++;
        end
        if (mis) begin
            m_mc++;
            if (m_mc4 < 15) m_mc4++;
        end
        sb.push_back(snapshot(mis));
        @(posedge CLK); #1;
        compare_out();
    endtask

    logic [31:0] pool [4];

    initial begin
        RST = 1'b1; ACT = 1'b0; STALL = 1'b0; op = 3'd0; pred = 1'b0;
        rs1 = '0; rs2 = '0; tgt = '0; ft = '0;
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
        #2;
        do_reset();

        // compare cases, correctly predicted so no redirects
        step(1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 1, 32'h40, 32'h44);
        check("blt_taken", 64'(ref_taken(3'd4, 32'hFFFF_FFFF, 32'd1)), 64'd1);
        step(1, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'h40, 32'h44);
        step(1, 0, 3'd5, 32'd5, 32'd5, 1, 32'h40, 32'h44);
        step(1, 0, 3'd7, 32'd0, 32'hFFFF_FFFF, 0, 32'h40, 32'h44);
        step(1, 0, 3'd3, 32'h1234, 32'h1234, 1, 32'h40, 32'h44);
        step(1, 0, 3'd2, 32'h1234, 32'h1234, 0, 32'h40, 32'h44);
        step(1, 0, 3'd0, 32'h1, 32'h2, 1, 32'h40, 32'h44);
        check("no_mispred_yet", 64'(mc), 64'd0);

        // mispredict, then squashed BNE during flush, then accepted at N+3 under STALL-free
        step(1, 0, 3'd3, 32'h1234, 32'h1234, 0, 32'h100, 32'h104);
        check("mis_rpc", 64'(rpc), 64'h100);
        step(1, 0, 3'd2, 32'h1, 32'h2, 0, 32'h200, 32'h204);
        step(1, 0, 3'd2, 32'h1, 32'h2, 0, 32'h200, 32'h204);
        step(1, 0, 3'd2, 32'h1, 32'h2, 0, 32'h200, 32'h204);
        // STALL through the whole flush window
        for (int i = 0; i < FC + 2; i++) step(1, 1, 3'd1, 32'h0, 32'h0, 0, 32'h300, 32'h304);
        check("flush_dropped", 64'(fl), 64'd0);

        // 20 correctly predicted jumps saturate the narrow counters
        for (int i = 0; i < 20; i++) step(1, 0, 3'd1, 32'h0, 32'h0, 1, 32'h400, 32'h404);
        check("sat_br4", 64'(bc4), 64'd15);

        // reset in the middle of a flush
        step(1, 0, 3'd6, 32'd1, 32'd2, 0, 32'h500, 32'h504);
        do_reset();
        check("rst_flush", 64'(fl), 64'd0);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
